// File: rtl/apb_master_arb.sv
// Two-port round-robin APB master arbiter and SETUP/ACCESS transfer sequencer.
// Optional ACCESS-phase timeout is enabled by defining APB_ARB_TIMEOUT_EN.
`ifndef PADDR_WIDTH
  `define PADDR_WIDTH 32
`endif
`ifndef APB_DATA_WIDTH
  `define APB_DATA_WIDTH 32
`endif

module apb_master_arb #(
  parameter int ADDR_WIDTH = `PADDR_WIDTH,
  parameter int DATA_WIDTH = `APB_DATA_WIDTH,
  parameter int TIMEOUT    = 255
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic                  req_0,
  input  logic [ADDR_WIDTH-1:0] addr_0,
  input  logic                  write_0,
  input  logic [DATA_WIDTH-1:0] wdata_0,
  output logic                  ack_0,
  output logic                  err_0,
  output logic [DATA_WIDTH-1:0] rdata_0,
  input  logic                  req_1,
  input  logic [ADDR_WIDTH-1:0] addr_1,
  input  logic                  write_1,
  input  logic [DATA_WIDTH-1:0] wdata_1,
  output logic                  ack_1,
  output logic                  err_1,
  output logic [DATA_WIDTH-1:0] rdata_1,
  output logic                  psel_en,
  output logic                  penable,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic                  pwrite,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic                  pready_x,
  input  logic                  pslverr_x,
  input  logic [DATA_WIDTH-1:0] prdata_x
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  state_e                     state_q, state_d;
  logic                       ptr_q, ptr_d, gnt_q, gnt_d;
  logic                       psel_q, psel_d, pen_q, pen_d, pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0]      paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0]      pwdata_q, pwdata_d;
  logic [1:0]                 ack_q, ack_d, err_q, err_d;
  logic [1:0][DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                       sel, done, done_err;
  logic [DATA_WIDTH-1:0]      done_rdata;

  if (TIMEOUT < 1 || TIMEOUT > 1023) begin : g_bad_timeout
    $error("apb_master_arb: TIMEOUT must be in 1..1023");
  end

`ifdef APB_ARB_TIMEOUT_EN
  localparam logic [9:0] TO_CNT = 10'(TIMEOUT);
  logic [9:0] wcnt_q, wcnt_d;
`endif

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    psel_d     = psel_q;
    pen_d      = pen_q;
    pwrite_d   = pwrite_q;
    paddr_d    = paddr_q;
    pwdata_d   = pwdata_q;
    ack_d      = 2'b00;
    err_d      = err_q;
    rdata_d    = rdata_q;
    done       = 1'b0;
    done_err   = pslverr_x;
    done_rdata = prdata_x;
    sel        = (req_0 && req_1) ? ~ptr_q : req_1;
`ifdef APB_ARB_TIMEOUT_EN
    wcnt_d     = wcnt_q;
`endif
    unique case (state_q)
      // The ack cycle is a turnaround: nobody is granted while an ack is out,
      // so a requester that holds req through its ack is not re-granted early
      // and every zero-wait transfer occupies exactly four cycles.
      IDLE: if (ack_q == 2'b00 && (req_0 || req_1)) begin
        state_d  = SETUP;
        gnt_d    = sel;
        ptr_d    = sel;
        psel_d   = 1'b1;
        paddr_d  = sel ? addr_1  : addr_0;
        pwrite_d = sel ? write_1 : write_0;
        pwdata_d = sel ? wdata_1 : wdata_0;
      end
      SETUP: begin
        state_d = ACCESS;
        pen_d   = 1'b1;
`ifdef APB_ARB_TIMEOUT_EN
        wcnt_d  = '0;
`endif
      end
      ACCESS: begin
        if (pready_x) done = 1'b1;
`ifdef APB_ARB_TIMEOUT_EN
        else if (wcnt_q == TO_CNT) begin
          done       = 1'b1;
          done_err   = 1'b1;
          done_rdata = '0;
        end
        else wcnt_d = wcnt_q + 10'd1;
`endif
        if (done) begin
          state_d        = IDLE;
          psel_d         = 1'b0;
          pen_d          = 1'b0;
          ack_d[gnt_q]   = 1'b1;
          err_d[gnt_q]   = done_err;
          if (!pwrite_q) rdata_d[gnt_q] = done_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q  <= IDLE;
      ptr_q    <= 1'b1;
      gnt_q    <= 1'b0;
      psel_q   <= 1'b0;
      pen_q    <= 1'b0;
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      ack_q    <= 2'b00;
      err_q    <= 2'b00;
      rdata_q  <= '0;
`ifdef APB_ARB_TIMEOUT_EN
      wcnt_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      psel_q   <= psel_d;
      pen_q    <= pen_d;
      pwrite_q <= pwrite_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
`ifdef APB_ARB_TIMEOUT_EN
      wcnt_q   <= wcnt_d;
`endif
    end
  end

  assign psel_en = psel_q;
  assign penable = pen_q;
  assign paddr   = paddr_q;
  assign pwrite  = pwrite_q;
  assign pwdata  = pwdata_q;
  assign ack_0   = ack_q[0];
  assign ack_1   = ack_q[1];
  assign err_0   = err_q[0];
  assign err_1   = err_q[1];
  assign rdata_0 = rdata_q[0];
  assign rdata_1 = rdata_q[1];

endmodule

// File: tb/tb_apb_master_arb.sv
// Directed self-checking bench for apb_master_arb; edge numbers count posedges
// after the request is driven, with outputs sampled 1ns after each posedge.
module tb_apb_master_arb;
  logic        hclk = 1'b0, hreset = 1'b1;
  logic        req_0 = 0, write_0 = 0, req_1 = 0, write_1 = 0;
  logic [31:0] addr_0 = 0, wdata_0 = 0, addr_1 = 0, wdata_1 = 0;
  logic        ack_0, err_0, ack_1, err_1;
  logic [31:0] rdata_0, rdata_1;
  logic        psel_en, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic        pready_x = 0, pslverr_x = 0;
  logic [31:0] prdata_x = 0;
  int          n_tests = 0, n_fail = 0;

  apb_master_arb #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(4)) dut (
    .hclk(hclk), .hreset(hreset),
    .req_0(req_0), .addr_0(addr_0), .write_0(write_0), .wdata_0(wdata_0),
    .ack_0(ack_0), .err_0(err_0), .rdata_0(rdata_0),
    .req_1(req_1), .addr_1(addr_1), .write_1(write_1), .wdata_1(wdata_1),
    .ack_1(ack_1), .err_1(err_1), .rdata_1(rdata_1),
    .psel_en(psel_en), .penable(penable), .paddr(paddr), .pwrite(pwrite),
    .pwdata(pwdata), .pready_x(pready_x), .pslverr_x(pslverr_x), .prdata_x(prdata_x)
  );

  always #5 hclk = ~hclk;

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    // reset state
    tick(); tick();
    chk("rst_psel", psel_en, 0); chk("rst_pen", penable, 0);
    chk("rst_ack", {ack_1, ack_0}, 0); chk("rst_err", {err_1, err_0}, 0);
    chk("rst_paddr", paddr, 0); chk("rst_pwdata", pwdata, 0);
    chk("rst_pwrite", pwrite, 0); chk("rst_rdata", {rdata_1, rdata_0}, 0);
    hreset = 0;

    // single zero-wait write on port 0
    pready_x = 1; prdata_x = 32'hAAAA_5555;
    req_0 = 1; addr_0 = 32'h4000_0010; write_0 = 1; wdata_0 = 32'hDEAD_BEEF;
    tick();
    chk("w_e1_psel", psel_en, 1); chk("w_e1_pen", penable, 0);
    chk("w_e1_paddr", paddr, 32'h4000_0010); chk("w_e1_pwdata", pwdata, 32'hDEAD_BEEF);
    chk("w_e1_pwrite", pwrite, 1);
    req_0 = 0; addr_0 = 32'h0BAD_0BAD; wdata_0 = 0;
    tick();
    chk("w_e2_pen", penable, 1); chk("w_e2_paddr", paddr, 32'h4000_0010);
    chk("w_e2_ack", ack_0, 0);
    tick();
    chk("w_e3_ack", ack_0, 1); chk("w_e3_err", err_0, 0);
    chk("w_e3_rdata", rdata_0, 0); chk("w_e3_psel", psel_en, 0);
    chk("w_e3_paddr_hold", paddr, 32'h4000_0010);
    tick();
    chk("w_e4_ack", ack_0, 0);

    // port 1 read, two wait states, slave error
    pready_x = 0; pslverr_x = 1; prdata_x = 32'h5555_AAAA;
    req_1 = 1; addr_1 = 32'h5000_0020; write_1 = 0;
    tick();
    chk("r_e1_paddr", paddr, 32'h5000_0020); chk("r_e1_pwrite", pwrite, 0);
    req_1 = 0;
    for (int e = 2; e <= 4; e++) begin
      tick();
      chk($sformatf("r_e%0d_pen", e), penable, 1);
      chk($sformatf("r_e%0d_ack", e), ack_1, 0);
    end
    pready_x = 1; prdata_x = 32'h1234_5678;
    tick();
    chk("r_e5_ack", {ack_1, ack_0}, 2'b10); chk("r_e5_err", err_1, 1);
    chk("r_e5_rdata", rdata_1, 32'h1234_5678); chk("r_e5_pen", penable, 0);
    pready_x = 0; pslverr_x = 0;
    tick();
    chk("r_e6_ack", ack_1, 0); chk("r_e6_err_hold", err_1, 1);

    // both requesting continuously from reset
    hreset = 1; tick(); hreset = 0;
    pready_x = 1;
    req_0 = 1; addr_0 = 32'h0000_1000; write_0 = 1; wdata_0 = 32'h1111_1111;
    req_1 = 1; addr_1 = 32'h0000_2000; write_1 = 1; wdata_1 = 32'h2222_2222;
    for (int e = 1; e <= 16; e++) begin
      logic [1:0] exp_ack;
      tick();
      exp_ack = (e == 3 || e == 11) ? 2'b01 : (e == 7 || e == 15) ? 2'b10 : 2'b00;
      chk($sformatf("rr_e%0d_ack", e), {ack_1, ack_0}, exp_ack);
      if (e == 1 || e == 9) chk($sformatf("rr_e%0d_paddr", e), paddr, 32'h0000_1000);
      if (e == 5 || e == 13) chk($sformatf("rr_e%0d_paddr", e), paddr, 32'h0000_2000);
    end
    req_0 = 0; req_1 = 0;
    tick();

    // reset during ACCESS with pready low
    pready_x = 0;
    req_0 = 1; addr_0 = 32'h0000_3000; write_0 = 0;
    tick(); tick();
    chk("rs_access_pen", penable, 1);
    hreset = 1; #1;
    chk("rs_async_psel", psel_en, 0); chk("rs_async_pen", penable, 0);
    tick();
    chk("rs_e_psel", psel_en, 0); chk("rs_e_ack", {ack_1, ack_0}, 0);
    hreset = 0;
    req_1 = 1; addr_1 = 32'h0000_4000; write_1 = 1;
    tick();
    chk("rs_tie_psel", psel_en, 1); chk("rs_tie_paddr", paddr, 32'h0000_3000);
    req_0 = 0; req_1 = 0;
    pready_x = 1; prdata_x = 32'hCAFE_0001;
    tick(); tick();
    chk("rs_ack0", {ack_1, ack_0}, 2'b01); chk("rs_rdata0", rdata_0, 32'hCAFE_0001);
    tick();

`ifdef APB_ARB_TIMEOUT_EN
    // timeout: 4 wait cycles then forced error completion
    pready_x = 0; prdata_x = 32'hFFFF_FFFF;
    req_0 = 1; addr_0 = 32'h0000_5000; write_0 = 0;
    tick();
    req_0 = 0;
    for (int e = 2; e <= 6; e++) begin
      tick();
      chk($sformatf("to_e%0d_pen", e), penable, 1);
      chk($sformatf("to_e%0d_ack", e), ack_0, 0);
    end
    tick();
    chk("to_e7_ack", ack_0, 1); chk("to_e7_err", err_0, 1);
    chk("to_e7_rdata", rdata_0, 0); chk("to_e7_psel", psel_en, 0);
    tick();
`else
    // without timeout ACCESS waits as long as the slave needs
    pready_x = 0;
    req_0 = 1; addr_0 = 32'h0000_5000; write_0 = 0;
    tick();
    req_0 = 0;
    for (int e = 2; e <= 21; e++) tick();
    chk("nt_wait_pen", penable, 1); chk("nt_wait_ack", ack_0, 0);
    pready_x = 1; pslverr_x = 0; prdata_x = 32'h0000_BEEF;
    tick();
    chk("nt_ack", ack_0, 1); chk("nt_err", err_0, 0); chk("nt_rdata", rdata_0, 32'h0000_BEEF);
    tick();
`endif

    // normal transfer after the long/timed-out one
    pready_x = 1; pslverr_x = 0;
    req_1 = 1; addr_1 = 32'h0000_6000; write_1 = 1; wdata_1 = 32'h6666_6666;
    tick();
    chk("nx_paddr", paddr, 32'h0000_6000);
    req_1 = 0;
    tick(); tick();
    chk("nx_ack1", {ack_1, ack_0}, 2'b10); chk("nx_err1", err_1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
